// File: rtl/montgomery_precompute_pkg.sv
// montgomery_precompute_pkg: shared widths and state encodings for the Montgomery precompute stage
package montgomery_precompute_pkg;
    localparam int LOG_BITS = 3;
    localparam int BITS = 1 << LOG_BITS;
    typedef enum logic [2:0] {
        PRE_IDLE   = 3'd0,
        PRE_RUN    = 3'd1,
        PRE_FINISH = 3'd7
    } state_t;
endpackage

// File: rtl/montgomery_precompute_if.sv
// montgomery_precompute_if: start/finish handshake plus operand and result buses
interface montgomery_precompute_if;
    import montgomery_precompute_pkg::*;
    logic start;
    logic [BITS-1:0] base;
    logic [BITS-1:0] N;
    logic busy;
    logic finish;
    logic err;
    logic [BITS-1:0] N_out;
    logic [BITS-1:0] N_prime;
    logic [BITS-1:0] one_mont;
    logic [BITS-1:0] base_mont;
    modport master (
        output start, base, N,
        input  busy, finish, err, N_out, N_prime, one_mont, base_mont
    );
    modport slave (
        input  start, base, N,
        output busy, finish, err, N_out, N_prime, one_mont, base_mont
    );
endinterface

// File: rtl/montgomery_precompute_mod_double.sv
// mod_double: 2x mod N for x < N, one conditional subtract
module mod_double
    import montgomery_precompute_pkg::*;
(
    input  logic [BITS-1:0] x,
    input  logic [BITS-1:0] N,
    output logic [BITS-1:0] r
);
    logic [BITS:0] t;
    logic [BITS:0] n_ext;
    assign t = {x, 1'b0};
    assign n_ext = {1'b0, N};
    assign r = (t >= n_ext) ? BITS'(t - n_ext) : t[BITS-1:0];
endmodule

// File: rtl/montgomery_precompute.sv
// montgomery_precompute: derives N_prime, 2^BITS mod N and base*2^BITS mod N by shift/add/subtract
module montgomery_precompute
    import montgomery_precompute_pkg::*;
(
    input logic clk,
    input logic rst,
    montgomery_precompute_if.slave bus
);
    state_t state, state_n;
    logic [LOG_BITS-1:0] counter;
    logic [BITS-1:0] n_reg, x_one, x_base, s, y;
    logic [BITS-1:0] x_one_n, x_base_n, s_n, y_n;
    logic legal, last;

    assign legal = bus.N[0] && bus.N != BITS'(1) && bus.base < bus.N;
    assign last = counter == LOG_BITS'(BITS - 1);

    mod_double u_one (.x(x_one), .N(n_reg), .r(x_one_n));
    mod_double u_base (.x(x_base), .N(n_reg), .r(x_base_n));

    // N is odd, so adding N<<i sets bit i of s while leaving lower bits alone
    always_comb begin
        s_n = s[counter] ? s : s + (n_reg << counter);
        y_n = s[counter] ? y : y | (BITS'(1) << counter);
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= PRE_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = PRE_IDLE;
        case (state)
            PRE_IDLE: state_n = bus.start ? (legal ? PRE_RUN : PRE_FINISH) : PRE_IDLE;
            PRE_RUN:  state_n = last ? PRE_FINISH : PRE_RUN;
            default:  state_n = PRE_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = state != PRE_IDLE;
        bus.finish = state == PRE_FINISH;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            counter <= '0;
            n_reg <= '0;
            x_one <= '0;
            x_base <= '0;
            s <= '0;
            y <= '0;
            bus.err <= 1'b0;
            bus.N_out <= '0;
            bus.N_prime <= '0;
            bus.one_mont <= '0;
            bus.base_mont <= '0;
        end else if (state == PRE_IDLE && bus.start) begin
            n_reg <= bus.N;
            counter <= '0;
            x_one <= BITS'(1);
            x_base <= bus.base;
            s <= '0;
            y <= '0;
            bus.err <= !legal;
            if (!legal) begin
                bus.N_out <= bus.N;
                bus.N_prime <= '0;
                bus.one_mont <= '0;
                bus.base_mont <= '0;
            end
        end else if (state == PRE_RUN) begin
            x_one <= x_one_n;
            x_base <= x_base_n;
            s <= s_n;
            y <= y_n;
            counter <= last ? counter : counter + LOG_BITS'(1);
            if (last) begin
                bus.N_out <= n_reg;
                bus.N_prime <= y_n;
                bus.one_mont <= x_one_n;
                bus.base_mont <= x_base_n;
            end
        end
    end
endmodule

// File: tb/tb_montgomery_precompute.sv
// tb_montgomery_precompute: scoreboard bench for the Montgomery precompute stage (BITS=8)
module tb_montgomery_precompute;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int passed = 0;
    logic [32:0] q[$];
    logic [32:0] got;

    montgomery_precompute_if bus();
    montgomery_precompute dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    assign got = {bus.err, bus.N_out, bus.N_prime, bus.one_mont, bus.base_mont};

    function automatic logic [32:0] model(input logic [7:0] n, input logic [7:0] b);
        int one, bm, np;
        if (!n[0] || n == 8'd1 || b >= n) return {1'b1, n, 24'h0};
        one = 256 % int'(n);
        bm = (int'(b) * 256) % int'(n);
        np = 0;
        for (int k = 0; k < 256; k++)
            if (((int'(n) * k) % 256) == 255) np = k;
        return {1'b0, n, 8'(np), 8'(one), 8'(bm)};
    endfunction

    task automatic issue(input logic [7:0] n, input logic [7:0] b, input bit push);
        @(negedge clk);
        bus.start = 1'b1;
        bus.N = n;
        bus.base = b;
        if (push) q.push_back(model(n, b));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_finish(output int cyc);
        cyc = 1;
        while (!bus.finish && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        bus.start = 1'b0;
        bus.N = '0;
        bus.base = '0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.finish, got} !== 35'h0)
            $display("FAIL reset: got %h required 0", {bus.busy, bus.finish, got});
        else passed++;
        rst = 1'b1;
    endtask

    task automatic test_basic(input logic [7:0] n, input logic [7:0] b, input int lat);
        int cyc;
        logic [32:0] e;
        issue(n, b, 1);
        wait_finish(cyc);
        e = q.pop_front();
        checks++;
        if (cyc !== lat) $display("FAIL latency n=%0d b=%0d: got %0d required %0d", n, b, cyc, lat);
        else passed++;
        checks++;
        if (got !== e) $display("FAIL result n=%0d b=%0d: got %h required %h", n, b, got, e);
        else passed++;
    endtask

    task automatic test_illegal;
        test_basic(8'd12, 8'd5, 1);
        test_basic(8'd13, 8'd13, 1);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.err !== 1'b1) $display("FAIL err_hold: got %b required 1", bus.err);
        else passed++;
    endtask

    task automatic test_reset_abort;
        bit seen = 0;
        issue(8'd13, 8'd5, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.finish, got} !== 35'h0)
            $display("FAIL abort_reset: got %h required 0", {bus.busy, bus.finish, got});
        else passed++;
        rst = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (bus.finish) seen = 1;
        end
        checks++;
        if (seen !== 1'b0) $display("FAIL abort_finish: got %b required 0", seen);
        else passed++;
        test_basic(8'd255, 8'd254, 9);
    endtask

    task automatic test_back_to_back;
        int cyc, idle;
        bit stable;
        logic [32:0] snap, e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.N = 8'd13;
        bus.base = 8'd5;
        repeat (4) q.push_back(model(8'd13, 8'd5));
        wait_finish(cyc);
        e = q.pop_front();
        checks++;
        if (got !== e) $display("FAIL b2b_first: got %h required %h", got, e);
        else passed++;
        for (int j = 0; j < 3; j++) begin
            snap = got;
            idle = 0;
            stable = 1;
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
                if (!bus.busy) idle++;
                if (got !== snap) stable = 0;
            end while (!bus.finish && cyc < 40);
            if (j == 2) bus.start = 1'b0;
            e = q.pop_front();
            checks++;
            if (cyc !== 10) $display("FAIL b2b_interval %0d: got %0d required 10", j, cyc);
            else passed++;
            checks++;
            if (idle !== 1) $display("FAIL b2b_idle %0d: got %0d required 1", j, idle);
            else passed++;
            checks++;
            if (stable !== 1'b1) $display("FAIL b2b_stable %0d: got %b required 1", j, stable);
            else passed++;
            checks++;
            if (got !== e) $display("FAIL b2b_result %0d: got %h required %h", j, got, e);
            else passed++;
        end
    endtask

    task automatic test_random;
        int cyc;
        logic [7:0] n, b;
        logic [32:0] e;
        logic [15:0] prod;
        for (int j = 0; j < 1000; j++) begin
            n = 8'($urandom_range(1, 127) * 2 + 1);
            b = 8'($urandom_range(0, int'(n) - 1));
            issue(n, b, 1);
            wait_finish(cyc);
            e = q.pop_front();
            prod = bus.N_out * bus.N_prime;
            checks++;
            if (cyc !== 9) $display("FAIL rand_latency n=%0d b=%0d: got %0d required 9", n, b, cyc);
            else passed++;
            checks++;
            if (got !== e) $display("FAIL rand_result n=%0d b=%0d: got %h required %h", n, b, got, e);
            else passed++;
            checks++;
            if (prod[7:0] !== 8'hff) $display("FAIL rand_inverse n=%0d: got %h required ff", n, prod[7:0]);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic(8'd13, 8'd5, 9);
        test_basic(8'd255, 8'd254, 9);
        test_illegal();
        test_basic(8'd13, 8'd5, 9);
        test_reset_abort();
        test_back_to_back();
        repeat (3) @(negedge clk);
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
